// File: rtl/interval_timer.sv
// Programmable interval timer with CTRL/PRESET/COUNT registers.
// One-shot and periodic modes, maskable interrupt with sticky flag.
module interval_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic [1:0]  Addr,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t      state;
   logic        en;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        sticky;

   logic        ctrl_we;
   logic        pre_we;

   assign ctrl_we = WE && (Addr == 2'd0);
   assign pre_we  = WE && (Addr == 2'd1);

   // Register writes and the count FSM; INT exit overrides a same-cycle
   // sticky clear, while a same-cycle CTRL write keeps its En value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         en     <= 1'b0;
         mode   <= 2'd0;
         im     <= 1'b0;
         preset <= 32'd0;
         count  <= 32'd0;
         sticky <= 1'b0;
      end else begin
         if (pre_we)
            preset <= Din;
         if (ctrl_we) begin
            en     <= Din[0];
            mode   <= Din[2:1];
            im     <= Din[3];
            sticky <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (en)
                  state <= LOAD;
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!en)
                  state <= IDLE;
               else if (count == 32'd0)
                  state <= INT;
               else
                  count <= count - 32'd1;
            end
            INT: begin
               if (mode == 2'd1) begin
                  state <= LOAD;
               end else begin
                  if (!ctrl_we)
                     en <= 1'b0;
                  sticky <= 1'b1;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

   // Interrupt: pulse in INT, held by sticky until the next CTRL write.
   assign IRQ = im & ((state == INT) | sticky);

   // Read mux straight off the registers.
   always_comb begin
      Dout = 32'd0;
      unique case (Addr)
         2'd0: Dout = {28'd0, im, mode, en};
         2'd1: Dout = preset;
         2'd2: Dout = count;
         2'd3: Dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer; expectations are queued
// when stimulus is driven and popped when the DUT is sampled.
module tb_interval_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        WE = 1'b0;
   logic [1:0]  Addr = 2'd0;
   logic [31:0] Din = 32'd0;
   logic [31:0] Dout;
   logic        IRQ;

   int ncmp = 0;
   int nfail = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   interval_timer dut (
      .clk  (clk),
      .rst  (rst),
      .WE   (WE),
      .Addr (Addr),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      ncmp++;
      if (sb.size() == 0) begin
         nfail++;
         $error("FAIL sb_empty observed=0x%h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            nfail++;
            $error("FAIL %s observed=0x%h expected=0x%h",
                   e.tag, obs, e.val);
         end
      end
   endtask

   task automatic rd(input string tag, input logic [1:0] a,
                     input logic [31:0] exp);
      Addr = a;
      push(tag, exp);
      #1;
      pop_cmp(Dout);
   endtask

   task automatic irq(input string tag, input logic exp);
      push(tag, {31'd0, exp});
      #1;
      pop_cmp({31'd0, IRQ});
   endtask

   // Drive now (between edges); lands on the next rising edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      WE   = 1'b1;
      Addr = a;
      Din  = d;
      @(negedge clk);
      WE   = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // reset state, held across an edge
      #2;
      rd("rst_ctrl", 2'd0, 32'd0);
      rd("rst_preset", 2'd1, 32'd0);
      rd("rst_count", 2'd2, 32'd0);
      irq("rst_irq", 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // register map
      wr(2'd1, 32'd20);
      wr(2'd0, 32'h1);
      tick(3);
      wr(2'd0, 32'h0);
      tick(1);
      rd("map_cnt_frozen", 2'd2, 32'd18);
      wr(2'd2, 32'h1234);
      rd("map_cnt_ro", 2'd2, 32'd18);
      wr(2'd3, 32'hFFFF);
      rd("map_rsvd", 2'd3, 32'd0);
      rd("map_preset", 2'd1, 32'd20);
      wr(2'd0, 32'hFFFF_FFFF);
      rd("map_ctrl_f", 2'd0, 32'hF);
      wr(2'd0, 32'h0);
      tick(4);
      irq("map_irq", 1'b0);

      // one-shot, PRESET=5
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      tick(7);
      irq("os_pre", 1'b0);
      rd("os_cnt0", 2'd2, 32'd0);
      tick(1);
      irq("os_rise", 1'b1);
      tick(1);
      irq("os_hold", 1'b1);
      rd("os_ctrl", 2'd0, 32'h8);
      rd("os_count", 2'd2, 32'd0);
      tick(3);
      irq("os_hold2", 1'b1);
      wr(2'd0, 32'h0);
      irq("os_clear", 1'b0);

      // periodic, PRESET=3
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      tick(5);
      irq("per_pre", 1'b0);
      tick(1);
      irq("per_p1", 1'b1);
      tick(1);
      irq("per_p1_end", 1'b0);
      rd("per_ctrl", 2'd0, 32'hB);
      tick(4);
      irq("per_gap", 1'b0);
      tick(1);
      irq("per_p2", 1'b1);
      wr(2'd0, 32'h0);
      tick(6);
      irq("per_off", 1'b0);

      // masked, PRESET=2
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      tick(5);
      irq("msk_int", 1'b0);
      tick(3);
      irq("msk_after", 1'b0);
      rd("msk_ctrl", 2'd0, 32'h0);
      wr(2'd0, 32'h8);
      irq("msk_unmask", 1'b0);
      wr(2'd0, 32'h0);

      // CTRL write colliding with INT exit
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      tick(3);
      irq("col_int", 1'b1);
      wr(2'd0, 32'h9);
      irq("col_sticky", 1'b1);
      rd("col_en_kept", 2'd0, 32'h9);
      wr(2'd0, 32'h0);
      tick(5);
      irq("col_off", 1'b0);

      // pause / resume, PRESET=10
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick(5);
      wr(2'd0, 32'h8);
      rd("pau_cnt6", 2'd2, 32'd6);
      tick(3);
      rd("pau_frozen", 2'd2, 32'd6);
      irq("pau_irq", 1'b0);
      wr(2'd0, 32'h9);
      rd("res_hold", 2'd2, 32'd6);
      tick(2);
      rd("res_reload", 2'd2, 32'd10);
      tick(3);
      rd("res_cnt7", 2'd2, 32'd7);

      // async reset between edges
      rst = 1'b1;
      rd("ar_ctrl", 2'd0, 32'd0);
      rd("ar_count", 2'd2, 32'd0);
      irq("ar_irq", 1'b0);
      WE   = 1'b1;
      Addr = 2'd1;
      Din  = 32'h55;
      @(negedge clk);
      WE  = 1'b0;
      rst = 1'b0;
      rd("ar_wr_drop", 2'd1, 32'd0);
      tick(5);
      rd("ar_idle_cnt", 2'd2, 32'd0);
      irq("ar_idle_irq", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- WE  in  1  register write enable from the bus bridge.
- Addr  in  2  word select, driven from bus address bits [3:2].
- Din  in  32  write data.
- Dout  out  32  read data.
- IRQ  out  1  interrupt request, wired to one HwInt bit of the coprocessor-0 stage.

REQ-002 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-003 The register map SHALL be as follows:
- Addr=0: CTRL, read/write. Bit 0 is En, bits [2:1] are Mode, bit 3 is IM; bits [31:4] read 0 and ignore writes.
- Addr=1: PRESET, read/write, 32 bits.
- Addr=2: COUNT, read-only; writes are ignored.
- Addr=3: reserved; reads 0, writes ignored.

REQ-004 Dout SHALL be combinational from Addr and reflect register values after the most recent clock edge.

REQ-005 The FSM SHALL have 4 states: IDLE, LOAD, CNT, INT. Transitions:
- IDLE: En=1 -> LOAD; otherwise stay in IDLE.
- LOAD: COUNT<=PRESET -> CNT.
- CNT: En=0 -> IDLE with COUNT held; else COUNT==0 -> INT; else COUNT<=COUNT-1.
- INT: if Mode==1, -> LOAD (periodic). Otherwise (Mode 0, 2 or 3), En<=0 and sticky<=1 -> IDLE.

REQ-006 IRQ SHALL equal IM & ((state==INT) | sticky).
- Periodic mode therefore gives a 1-cycle pulse per period.
- One-shot mode holds IRQ until software clears it.

REQ-007 Any CTRL write SHALL clear sticky. A write to PRESET or COUNT SHALL NOT affect sticky.

REQ-008 A CTRL write in the same cycle as the INT-state En clear SHALL win: the written En value is kept. sticky SHALL still be set by the INT exit in that cycle, and then cleared on the next CTRL write.

REQ-009 A PRESET write SHALL take effect only at the next LOAD; an in-progress count is unaffected.

REQ-010 A CTRL write with En=0 while in CNT SHALL stop counting on the next edge, with COUNT frozen. Re-enabling SHALL pass through LOAD, which reloads PRESET.

REQ-011 With PRESET=0, the sequence SHALL be LOAD -> CNT -> INT. The interrupt occurs 3 edges after the enable write.

REQ-012 Latency: with PRESET=N and a CTRL write setting En at edge k, state SHALL be INT after edge k+3+N.

REQ-013 COUNT SHALL never wrap. Decrementing stops at 0.

REQ-014 All arithmetic SHALL be unsigned, 32-bit.

Reset
REQ-015 While rst=1, the block SHALL hold CTRL=0, PRESET=0, COUNT=0, sticky=0, state=IDLE, and IRQ=0, independent of clk.

REQ-016 Reset asserted mid-count SHALL abort immediately with no IRQ pulse. After release, the block SHALL stay in IDLE until En is written.

REQ-017 Writes presented while rst=1 SHALL be discarded.

Verification
REQ-018 One-shot: write PRESET=5, then CTRL=0x9 at edge k. Required:
- IRQ rises after edge k+8 and stays 1.
- CTRL reads 0x8 and COUNT reads 0.
- Writing CTRL=0x0 drops IRQ after the next edge.

REQ-019 Periodic: PRESET=3, CTRL=0xB. Required: IRQ is a 1-cycle pulse every 6 cycles (LOAD + 4 CNT + INT), and En stays 1.

REQ-020 Masked: PRESET=2, CTRL=0x1. Required:
- IRQ stays 0 throughout.
- After expiry, a CTRL write of 0x8 shows IRQ=0, because sticky is cleared by that write.

REQ-021 Pause/resume: PRESET=10, CTRL=0x9. Required:
- Writing CTRL=0x8 after 4 CNT cycles freezes COUNT at 6.
- Writing CTRL=0x9 reloads COUNT to 10 via LOAD.

REQ-022 Async reset: assert rst between clock edges while COUNT=7. Required: COUNT, CTRL, and IRQ read 0 before the next clk edge.

REQ-023 Register map: write Addr=2 with 0x1234 -> COUNT unchanged. Write Addr=3 -> Dout=0. Write CTRL=0xFFFFFFFF -> CTRL reads 0xF.
